// File: rtl/pipelined_adder_pkg.sv
// Shared sizing helpers for the pipelined adder: slice width derivation and legality of WIDTH/STAGES.
// Purely elaboration-time; no logic, no latency, no backpressure.
package adder_pkg;

    function automatic int chunk_of(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for the pipelined adder; valid/ready on both the operand and result sides.
// Signals only: latency and backpressure are defined by the module on the slave side.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  a, b, cin, sub, in_valid, out_ready,
        output in_ready, out, cout, ovf, out_valid
    );

    modport master (
        output a, b, cin, sub, in_valid, out_ready,
        input  in_ready, out, cout, ovf, out_valid
    );
endinterface

// File: rtl/pipelined_adder_slice.sv
// Combinational CHUNK-bit ripple adder built from fulladder cells; exposes the carry into the top bit for overflow.
// Zero latency, no handshake.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] out,
    output logic             cout,
    output logic             cmsb
);
    // Per-bit carry nets live in their own generate scope so each link is a distinct net.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci),
            .s    (out[i]),
            .cout (co)
        );
    end

    assign cout = g_bit[CHUNK-1].co;
    assign cmsb = g_bit[CHUNK-1].ci;
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/sub split into STAGES ripple slices, one slice per rank; result valid STAGES-1 edges after accept.
// Backpressure ripples combinationally through the ready chain so a full pipe still accepts on a pop.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic             clk,
    input logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_of(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES must lie in 1..WIDTH");
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic              ovf_q;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] take;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  nxt_res [STAGES];

    logic [CHUNK-1:0]  sl_a [STAGES];
    logic [CHUNK-1:0]  sl_b [STAGES];
    logic [CHUNK-1:0]  sl_s [STAGES];
    logic              sl_c  [STAGES];
    logic              sl_co [STAGES];
    logic              sl_cm [STAGES];

    // A rank can take new data when empty or when its successor drains it this cycle.
    always_comb begin
        logic r;
        r           = bus.out_ready;
        rdy[STAGES] = r;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !vld_q[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        src_vld[0] = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = bus.sub ? ~bus.b : bus.b;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = opa_q[k-1];
            src_b[k]   = opb_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        assign sl_a[k] = src_a[k][k*CHUNK +: CHUNK];
        assign sl_b[k] = src_b[k][k*CHUNK +: CHUNK];
        if (k == 0) begin : g_c0
            assign sl_c[k] = bus.cin ^ bus.sub;
        end else begin : g_ck
            assign sl_c[k] = cy_q[k-1];
        end
        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (sl_a[k]),
            .b    (sl_b[k]),
            .cin  (sl_c[k]),
            .out  (sl_s[k]),
            .cout (sl_co[k]),
            .cmsb (sl_cm[k])
        );
    end

    always_comb begin
        nxt_res[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            nxt_res[k] = res_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            nxt_res[k][k*CHUNK +: CHUNK] = sl_s[k];
            take[k] = src_vld[k] && rdy[k];
        end
    end

    // Data registers load only on a transfer so outputs keep their last value once valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= src_vld[k];
                end
                if (take[k]) begin
                    res_q[k] <= nxt_res[k];
                    opa_q[k] <= src_a[k];
                    opb_q[k] <= src_b[k];
                    cy_q[k]  <= sl_co[k];
                end
            end
            if (take[STAGES-1]) begin
                ovf_q <= sl_co[STAGES-1] ^ sl_cm[STAGES-1];
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out       = res_q[STAGES-1];
    assign bus.cout      = cy_q[STAGES-1];
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = vld_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder against an arithmetic reference model with an in-flight queue.
module tb_pipelined_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] out;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) ifc ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pushes   = 0;
    int          pops     = 0;
    int          blocked  = 0;
    bit          lat_on   = 1'b0;
    bit          use_ovr  = 1'b0;
    exp_t        ovr;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow, borrow-inverted carry for subtract.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        exp_t        e;
        logic [32:0] u;
        longint      sa, sbv, s;
        int          c;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        c   = ci ? 1 : 0;
        if (sb) begin
            u      = {1'b0, a} - {1'b0, b} - 33'(c);
            s      = sa - sbv - longint'(c);
            e.cout = ~u[32];
        end else begin
            u      = {1'b0, a} + {1'b0, b} + 33'(c);
            s      = sa + sbv + longint'(c);
            e.cout = u[32];
        end
        e.out = u[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.cyc = 0;
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, observe 1 ns later, account for both transfers.
    task automatic cycle_io(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sb, input logic ordy);
        exp_t        e;
        logic [33:0] cur;
        @(negedge clk);
        ifc.in_valid  = v;
        ifc.a         = a;
        ifc.b         = b;
        ifc.cin       = ci;
        ifc.sub       = sb;
        ifc.out_ready = ordy;
        #1;
        cyc++;
        cur = {ifc.ovf, ifc.cout, ifc.out};
        chk("in_ready", 64'(ifc.in_ready), 64'(!(exp_q.size() >= STAGES && !ordy)));
        if (!ifc.in_ready) blocked++;
        if (prev_stall) chk("hold_outputs", 64'(cur), 64'(prev_out));
        if (lat_on)
            chk("out_valid", 64'(ifc.out_valid),
                64'(exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= STAGES));
        prev_stall = ifc.out_valid && !ordy;
        prev_out   = cur;
        if (ifc.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 64'(ifc.out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                pops++;
                chk("result", 64'(cur), 64'({e.ovf, e.cout, e.out}));
                if (lat_on) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
            end
        end
        if (v && ifc.in_ready) begin
            e     = use_ovr ? ovr : model(a, b, ci, sb);
            e.cyc = cyc;
            exp_q.push_back(e);
            pushes++;
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle_io(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ordy);
    endtask

    task automatic send_dir(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                            input logic [31:0] eo, input logic ec, input logic ev);
        ovr     = '{out: eo, cout: ec, ovf: ev, cyc: 0};
        use_ovr = 1'b1;
        cycle_io(1'b1, a, b, ci, sb, 1'b1);
        use_ovr = 1'b0;
    endtask

    task automatic send_rand(input logic ordy);
        cycle_io(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
    endtask

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;
        ifc.sub       = 1'b0;
        ifc.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out", 64'(ifc.out), 64'(0));
        chk("rst_cout", 64'(ifc.cout), 64'(0));
        chk("rst_ovf", 64'(ifc.ovf), 64'(0));
        chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(ifc.in_ready), 64'(1));

        // Full-width carry ripple, then subtract and signed overflow, with exact latency
        lat_on = 1'b1;
        send_dir(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        idle(6, 1'b1);
        send_dir(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_dir(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_dir(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        idle(6, 1'b1);
        chk("directed_drained", 64'(exp_q.size()), 64'(0));

        // Back-to-back random stream, one result per cycle
        for (int i = 0; i < 8; i++) send_rand(1'b1);
        idle(6, 1'b1);
        chk("stream_drained", 64'(exp_q.size()), 64'(0));

        // Continuous stream with a 5-cycle output stall
        lat_on  = 1'b0;
        blocked = 0;
        for (int i = 0; i < 20; i++) send_rand(!(i >= 3 && i < 8));
        chk("backpressure_seen", 64'(blocked > 0), 64'(1));
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1, 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'(0));
        chk("bp_no_loss_dup", 64'(pops), 64'(pushes));

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) send_rand(1'b0);
        idle(2, 1'b0);
        chk("pre_rst_out_valid", 64'(ifc.out_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(ifc.out_valid), 64'(0));
        chk("midrst_out", 64'(ifc.out), 64'(0));
        chk("midrst_cout_ovf", 64'({ifc.cout, ifc.ovf}), 64'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        lat_on = 1'b1;
        idle(8, 1'b1);
        for (int i = 0; i < 3; i++) send_rand(1'b1);
        idle(6, 1'b1);
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
